store_monitor: RTL and testbench

Synthesizable store-stream observer that sits directly downstream of the pipeline top's data-memory write port. It watches `memwrite`, `dataaddr`, `writedata` and `pc` each cycle, logs every store into a small first-word-fall-through FIFO, and issues a sticky pass/fail verdict. The verdict is based on the program's signature store or on a cycle timeout. The testbench and on-board debug logic read back the verdict and the store log.

---
 rtl/store_monitor_pkg.sv | 41 ++++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/store_monitor.sv | 112 +++++++++++
 tb/tb_store_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_monitor_pkg.sv
// ============================================================================
// Module   : store_monitor_pkg
// Brief    : Shared types, fail codes and store-log entry layout.
// Revision : 1.0
// ============================================================================
`default_nettype none

package store_monitor_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_ALIGN   = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  localparam int ENTRY_W  = 96;
  localparam int OFF_DATA = 0;
  localparam int OFF_ADDR = 32;
  localparam int OFF_PC   = 64;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [31:0] i_pc,
    input logic [31:0] i_addr,
    input logic [31:0] i_data
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[OFF_PC   +: 32] = i_pc;
    e[OFF_ADDR +: 32] = i_addr;
    e[OFF_DATA +: 32] = i_data;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : First-word-fall-through FIFO; reports pushes it had to drop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_drop,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);
  // A pop on an empty FIFO is ignored; a pop frees the slot a full-FIFO push needs.
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_valid = !w_empty;
  assign o_drop  = i_push && !w_push;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/store_monitor.sv
// ============================================================================
// Module   : store_monitor
// Brief    : Logs data-memory stores and latches a pass/fail verdict.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] PASS_ADDR = 32'd84,
  parameter logic [31:0] PASS_DATA = 32'd7,
  parameter int          TIMEOUT   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   memwrite,
  input  logic [31:0]            dataaddr,
  input  logic [31:0]            writedata,
  input  logic [31:0]            pc,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [31:0]            rd_pc,
  output logic [31:0]            rd_addr,
  output logic [31:0]            rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic [1:0]             fail_code
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_fail_code;
  logic [1:0]       w_code_nxt;
  logic [TW-1:0]    r_tmo_cnt;
  logic             r_overflow;
  logic             w_push;
  logic             w_drop;
  logic [ENTRY_W-1:0] w_head;

  assign w_push = memwrite && (r_state == RUN);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (pack_entry(pc, dataaddr, writedata)),
    .i_pop   (rd_en),
    .o_data  (w_head),
    .o_valid (rd_valid),
    .o_drop  (w_drop),
    .o_count (count)
  );

  // A verdict store in the last RUN cycle wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_fail_code;
    if (r_state == RUN) begin
      if (memwrite && (dataaddr[1:0] != 2'b00)) begin
        w_state_nxt = FAIL;
        w_code_nxt  = FC_ALIGN;
      end else if (memwrite && (dataaddr == PASS_ADDR)) begin
        if (writedata == PASS_DATA) begin
          w_state_nxt = PASS;
        end else begin
          w_state_nxt = FAIL;
          w_code_nxt  = FC_DATA;
        end
      end else if (r_tmo_cnt == c_tmo_last) begin
        w_state_nxt = FAIL;
        w_code_nxt  = FC_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_fail_code <= FC_NONE;
      r_tmo_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fail_code <= w_code_nxt;
      if (r_state == RUN) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      if (w_drop)         r_overflow <= 1'b1;
    end
  end

  assign rd_pc     = w_head[OFF_PC   +: 32];
  assign rd_addr   = w_head[OFF_ADDR +: 32];
  assign rd_data   = w_head[OFF_DATA +: 32];
  assign overflow  = r_overflow;
  assign done      = (r_state != RUN);
  assign pass      = (r_state == PASS);
  assign fail      = (r_state == FAIL);
  assign fail_code = r_fail_code;

endmodule

`default_nettype wire

// File: tb/tb_store_monitor.sv
// ============================================================================
// Module   : tb_store_monitor
// Brief    : Directed and random stimulus against a queue-based reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_store_monitor;

  localparam int          DEPTH   = 8;
  localparam int          TIMEOUT = 32;
  localparam logic [31:0] P_ADDR  = 32'd84;
  localparam logic [31:0] P_DATA  = 32'd7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memwrite;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic [31:0] pc;
  logic        rd_en;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  count;
  logic        overflow;
  logic        done;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;

  always #5 clk = ~clk;

  store_monitor #(
    .DEPTH     (DEPTH),
    .PASS_ADDR (P_ADDR),
    .PASS_DATA (P_DATA),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .memwrite  (memwrite),
    .dataaddr  (dataaddr),
    .writedata (writedata),
    .pc        (pc),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid),
    .rd_pc     (rd_pc),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .count     (count),
    .overflow  (overflow),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .fail_code (fail_code)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  // Reference model: log as a bounded queue, verdict as 0=running 1=pass 2=fail.
  ent_t q[$];
  int   m_st;
  int   m_code;
  int   m_runcyc;
  bit   m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_st     = 0;
    m_code   = 0;
    m_runcyc = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(input bit mw, input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] p, input bit rd);
    bit popped;
    bit wants;
    bit acc;
    popped = rd && (q.size() > 0);
    wants  = mw && (m_st == 0);
    acc    = wants && ((q.size() < DEPTH) || popped);
    if (wants && !acc) m_ovf = 1'b1;
    if (popped) void'(q.pop_front());
    if (acc) q.push_back({p, addr, data});
    if (m_st == 0) begin
      m_runcyc++;
      if (mw && (addr[1:0] != 2'b00)) begin
        m_st = 2; m_code = 2;
      end else if (mw && addr == P_ADDR) begin
        if (data == P_DATA) m_st = 1;
        else begin m_st = 2; m_code = 1; end
      end else if (m_runcyc == TIMEOUT) begin
        m_st = 2; m_code = 3;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    ent_t h;
    h = '0;
    if (q.size() > 0) h = q[0];
    check({ctx, ".rd_valid"},  32'(rd_valid),  32'(q.size() != 0));
    check({ctx, ".count"},     32'(count),     32'(q.size()));
    check({ctx, ".rd_pc"},     rd_pc,          h.pc);
    check({ctx, ".rd_addr"},   rd_addr,        h.addr);
    check({ctx, ".rd_data"},   rd_data,        h.data);
    check({ctx, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({ctx, ".done"},      32'(done),      32'(m_st != 0));
    check({ctx, ".pass"},      32'(pass),      32'(m_st == 1));
    check({ctx, ".fail"},      32'(fail),      32'(m_st == 2));
    check({ctx, ".fail_code"}, 32'(fail_code), 32'(m_code));
  endtask

  // Reset lands between clock edges; outputs must clear before any edge arrives.
  task automatic do_reset();
    reset_n  = 1'b0;
    memwrite = 1'b0;
    rd_en    = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    #2;
    reset_n = 1'b1;
  endtask

  task automatic step(input bit mw, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] p, input bit rd, input string ctx);
    memwrite  = mw;
    dataaddr  = addr;
    writedata = data;
    pc        = p;
    rd_en     = rd;
    @(posedge clk);
    model_edge(mw, addr, data, p, rd);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input int n, input string ctx);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, ctx);
  endtask

  initial begin
    memwrite = 1'b0; dataaddr = '0; writedata = '0; pc = '0; rd_en = 1'b0;

    // Signature store
    do_reset();
    step(1'b1, 32'd80, 32'd5, 32'h10, 1'b0, "sig_st1");
    step(1'b1, 32'd84, 32'd7, 32'h14, 1'b0, "sig_st2");
    check("sig_pass", 32'(pass), 32'd1);
    check("sig_count", 32'(count), 32'd2);
    check("sig_head_addr", rd_addr, 32'd80);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, "sig_pop1");
    check("sig_pop1_pc", rd_pc, 32'h14);
    check("sig_pop1_data", rd_data, 32'd7);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, "sig_pop2");

    // Wrong data, then post-verdict store ignored
    do_reset();
    step(1'b1, 32'd84, 32'd6, 32'h20, 1'b0, "wrong_data");
    check("wrong_code", 32'(fail_code), 32'd1);
    step(1'b1, 32'd84, 32'd7, 32'h24, 1'b0, "after_fail");
    check("after_fail_count", 32'(count), 32'd1);

    // Misaligned store
    do_reset();
    step(1'b1, 32'd86, 32'd7, 32'h30, 1'b0, "misalign");
    check("misalign_code", 32'(fail_code), 32'd2);
    check("misalign_logged", rd_addr, 32'd86);

    // Timeout at the 32nd edge
    do_reset();
    idle(TIMEOUT - 1, "tmo_wait");
    check("tmo_done_early", 32'(done), 32'd0);
    idle(1, "tmo_fire");
    check("tmo_code", 32'(fail_code), 32'd3);

    // Signature store on the timeout edge wins
    do_reset();
    idle(TIMEOUT - 1, "tmo_sig_wait");
    step(1'b1, 32'd84, 32'd7, 32'h40, 1'b0, "tmo_sig");
    check("tmo_sig_pass", 32'(pass), 32'd1);

    // FIFO boundaries
    do_reset();
    step(1'b1, 32'd100, 32'd1, 32'h50, 1'b1, "empty_pushpop");
    check("empty_pushpop_count", 32'(count), 32'd1);
    for (int i = 1; i < DEPTH; i++)
      step(1'b1, 32'(100 + 4 * i), 32'(i), 32'(32'h50 + 4 * i), 1'b0, "fill");
    check("full_count", 32'(count), 32'd8);
    step(1'b1, 32'd200, 32'd9, 32'h90, 1'b1, "full_pushpop");
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    step(1'b1, 32'd204, 32'd10, 32'h94, 1'b0, "full_push");
    check("full_push_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, "drain");

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'(16 + 4 * i), 32'(i + 1), 32'(32'h60 + 4 * i), 1'b0, "pre_reset");
    do_reset();
    check("mid_reset_valid", 32'(rd_valid), 32'd0);
    idle(1, "post_reset");

    // Random runs
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 50; c++) begin
        bit          mw;
        bit          rd;
        int          sel;
        logic [31:0] a;
        logic [31:0] d;
        mw  = ($urandom_range(0, 99) < 55);
        rd  = ($urandom_range(0, 99) < 30);
        sel = $urandom_range(0, 29);
        d   = $urandom_range(0, 15);
        if (sel == 0)      begin a = P_ADDR; d = ($urandom_range(0, 1) != 0) ? P_DATA : d; end
        else if (sel == 1) a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        else               a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        step(mw, a, d, $urandom, rd, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
